// File: rtl/vc_input_ctrl.sv
// ---------------------------------------------------------------------------
// vc_input_ctrl
//
// Virtual-channel input controller for one router input port. The link side
// writes flits into NUM_VC per-channel FIFOs (BUFFER_DEPTH entries each), and
// the router side reads head flits from them. A free-running phase rotor p
// picks the write VC (p) and the read VC (p+1 mod NUM_VC) every cycle. With
// NUM_VC=2 this is the classic odd/even alternating input controller.
//
// Parameters
//   DATA_WIDTH    flit width (default 64)
//   NUM_VC        number of virtual channels, 2..16 (default 2)
//   BUFFER_DEPTH  entries per VC FIFO, >= 1, need not be a power of two
//   VC_W          (derived) VC index width, clog2(NUM_VC)
//
// Ports
//   clk                in   rising-edge clock
//   rst                in   synchronous, active-low reset
//   sendI              in   link strobe, dataI valid this cycle
//   dataI              in   link flit
//   receiveI           out  write VC can accept a flit this cycle
//   sig_channel_clean  in   router grant, pop head of read VC this cycle
//   sig_req_channel    out  read VC holds at least one flit
//   inner_dataO        out  head flit of read VC (zero when none)
//   inner_vcO          out  current read VC index
//   wr_vcO             out  current write VC index
//   drop_cnt           out  dropped-flit counter
//
// Build option
//   INPUT_CTRL_STATS_EN  when defined, drop_cnt counts every cycle in which
//                        sendI is high but the flit cannot be accepted
//                        (saturating at 16'hFFFF). When undefined, drop_cnt
//                        is tied to zero and no counter exists.
// ---------------------------------------------------------------------------
module vc_input_ctrl #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_VC       = 2,
    parameter int BUFFER_DEPTH = 2,
    localparam int VC_W        = $clog2(NUM_VC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sendI,
    input  logic [DATA_WIDTH-1:0] dataI,
    output logic                  receiveI,
    input  logic                  sig_channel_clean,
    output logic                  sig_req_channel,
    output logic [DATA_WIDTH-1:0] inner_dataO,
    output logic [VC_W-1:0]       inner_vcO,
    output logic [VC_W-1:0]       wr_vcO,
    output logic [15:0]           drop_cnt
);

    // A depth-1 FIFO still needs a 1-bit pointer so the declarations stay legal.
    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

    localparam logic [VC_W-1:0]  LAST_VC  = VC_W'(NUM_VC - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [VC_W-1:0] p_q, p_d;
    logic [VC_W-1:0] rd_vc;
    logic            run;
    logic            push;
    logic            pop;

    logic [NUM_VC-1:0]     full_vec;
    logic [NUM_VC-1:0]     empty_vec;
    logic [DATA_WIDTH-1:0] head_vec [NUM_VC];

    // -----------------------------------------------------------------------
    // Phase rotor and control FSM
    // -----------------------------------------------------------------------
    assign run = (state_q == RUN);

    // Read VC is always the write VC's successor, so the two never coincide
    // and a push and a pop in one cycle always hit different FIFOs.
    assign rd_vc = (p_q == LAST_VC) ? '0 : p_q + 1'b1;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        case (state_q)
            IDLE: state_d = RUN;
            RUN:  p_d     = rd_vc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
        end
    end

    // -----------------------------------------------------------------------
    // Handshake decode: everything here comes from registers only, so no
    // input reaches an output combinationally.
    // -----------------------------------------------------------------------
    assign receiveI        = run && !full_vec[p_q];
    assign sig_req_channel = run && !empty_vec[rd_vc];
    assign push            = sendI && receiveI;
    assign pop             = sig_channel_clean && sig_req_channel;

    // Head is forced to zero when the read VC has nothing valid, which also
    // hides stale or never-written storage after a flush.
    assign inner_dataO = sig_req_channel ? head_vec[rd_vc] : '0;
    assign inner_vcO   = rd_vc;
    assign wr_vcO      = p_q;

    // -----------------------------------------------------------------------
    // Per-VC FIFOs
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
            logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
            logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0]      cnt_q, cnt_d;
            logic                  vc_push;
            logic                  vc_pop;

            assign vc_push = push && (p_q == VC_W'(gi));
            assign vc_pop  = pop && (rd_vc == VC_W'(gi));

            // Pointers wrap explicitly at BUFFER_DEPTH-1 because the depth
            // need not be a power of two.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                cnt_d    = cnt_q;
                if (vc_push) begin
                    wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
                if (vc_pop) begin
                    rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                end
            end

            // Storage carries no reset; the count alone defines validity.
            always_ff @(posedge clk) begin
                if (vc_push) begin
                    mem_q[wr_ptr_q] <= dataI;
                end
            end

            assign full_vec[gi]  = (cnt_q == FULL_CNT);
            assign empty_vec[gi] = (cnt_q == '0);
            assign head_vec[gi]  = mem_q[rd_ptr_q];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Drop statistics
    // -----------------------------------------------------------------------
`ifdef INPUT_CTRL_STATS_EN
    logic        drop;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A drop can happen in IDLE too, since receiveI is low there.
    assign drop = sendI && !receiveI;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule
